// File: rtl/mine_placer.sv
// mine_placer: scatters mines on the board from a serial random bit stream at game start.
// Optional macro MINE_PLACER_SAFE_ZONE_EN protects the whole 3x3 neighbourhood of the safe cell.
module mine_placer #(
  parameter int unsigned BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] board_cols,
  input  logic [4:0] board_rows,
  input  logic [7:0] mine_count,
  input  logic [3:0] safe_x,
  input  logic [3:0] safe_y,
  input  logic       random_data,
  output logic       busy,
  output logic       done,
  output logic       wr_en,
  output logic [3:0] wr_x,
  output logic [3:0] wr_y,
  output logic [7:0] placed
);

  localparam int unsigned DIV_W   = 4;
  localparam int unsigned CELLS   = 256;
  localparam int unsigned COORD_W = 4;
`ifdef MINE_PLACER_SAFE_ZONE_EN
  localparam int unsigned EXCLUDED = 9;
`else
  localparam int unsigned EXCLUDED = 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GATHER,
    S_CHECK,
    S_PLACE,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [4:0]         cols_q;
  logic [4:0]         rows_q;
  logic [7:0]         count_q;
  logic [3:0]         safe_x_q;
  logic [3:0]         safe_y_q;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         bit_cnt_q;
  logic [7:0]         shift_q;
  logic [CELLS-1:0]   occ_q;

  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic signed [8:0]  avail;
  logic [7:0]         target;
  logic               take_bit;
  logic               bit_end;
  logic               last_bit;
  logic               protected_hit;
  logic               reject;
  logic               last_mine;

  assign cand_x   = shift_q[7:4];
  assign cand_y   = shift_q[3:0];
  assign take_bit = (div_q == '0);
  assign bit_end  = (div_q == DIV_W'(BIT_DIV - 1));
  assign last_bit = bit_end && (bit_cnt_q == 3'd7);

  // Free cells after exclusion; modulo-512 wrap keeps 16x16 exact.
  assign avail = $signed(9'(cols_q) * 9'(rows_q) - 9'(EXCLUDED));

  always_comb begin
    target = '0;
    if (avail > 9'sd0) begin
      target = (count_q < avail[7:0]) ? count_q : avail[7:0];
    end
  end

`ifdef MINE_PLACER_SAFE_ZONE_EN
  function automatic logic near(input logic [3:0] a, input logic [3:0] b);
    return (a == b) || ((5'(a) + 5'd1) == 5'(b)) || ((5'(b) + 5'd1) == 5'(a));
  endfunction

  assign protected_hit = near(cand_x, safe_x_q) && near(cand_y, safe_y_q);
`else
  assign protected_hit = (cand_x == safe_x_q) && (cand_y == safe_y_q);
`endif

  assign reject = ({1'b0, cand_x} >= cols_q) ||
                  ({1'b0, cand_y} >= rows_q) ||
                  occ_q[{cand_y, cand_x}]    ||
                  protected_hit;

  assign last_mine = (({1'b0, placed} + 9'd1) == {1'b0, target});

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:   if (start) state_d = S_CLEAR;
      S_CLEAR:  state_d = (target == '0) ? S_DONE : S_GATHER;
      S_GATHER: if (last_bit) state_d = S_CHECK;
      S_CHECK:  state_d = reject ? S_GATHER : S_PLACE;
      S_PLACE:  state_d = last_mine ? S_DONE : S_GATHER;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Game parameters, captured only when a start is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cols_q   <= '0;
      rows_q   <= '0;
      count_q  <= '0;
      safe_x_q <= '0;
      safe_y_q <= '0;
    end else if (state == S_IDLE && start) begin
      cols_q   <= board_cols;
      rows_q   <= board_rows;
      count_q  <= mine_count;
      safe_x_q <= safe_x;
      safe_y_q <= safe_y;
    end
  end

  // Bit sampler: divider and bit counter run only while gathering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else if (state == S_GATHER) begin
      div_q <= bit_end ? '0 : div_q + DIV_W'(1);
      if (take_bit) shift_q <= {shift_q[6:0], random_data};
      if (bit_end) bit_cnt_q <= bit_cnt_q + 3'd1;
    end else begin
      div_q     <= '0;
      bit_cnt_q <= '0;
    end
  end

  // Occupancy map and placed counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q  <= '0;
      placed <= '0;
    end else if (state == S_CLEAR) begin
      occ_q  <= '0;
      placed <= '0;
    end else if (state == S_PLACE) begin
      occ_q[{cand_y, cand_x}] <= 1'b1;
      placed                  <= placed + 8'd1;
    end
  end

  // Registered status and write port, decoded from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      wr_en <= 1'b0;
      wr_x  <= '0;
      wr_y  <= '0;
    end else begin
      busy  <= (state_d != S_IDLE);
      done  <= (state_d == S_DONE);
      wr_en <= (state_d == S_PLACE);
      if (state_d == S_PLACE) begin
        wr_x <= cand_x;
        wr_y <= cand_y;
      end
    end
  end

endmodule

// File: doc/mine_placer.md
# mine_placer

Sequences the free-running 1-bit random generator to scatter mines on the Saper board at game start. On `start` it clears an internal occupancy map and assembles random (x, y) coordinates from serial random bits. It rejects out-of-range, already-mined and protected cells, and issues one write per accepted mine to the board mine memory. It sits between the game control FSM, which starts it, and the board memory, which it writes.

## Interface
- `BIT_DIV`, 1: `random_data` is sampled once every `BIT_DIV` clocks (range 1..16).
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: request placement; one-cycle pulse, accepted only in IDLE.
- `board_cols` in 5: column count, 2..16.
- `board_rows` in 5: row count, 2..16.
- `mine_count` in 8: requested mines, 0..255.
- `safe_x`, `safe_y` in 4 each: protected cell, normally the first click.
- `random_data` in 1: serial random bit from the generator.
- `busy` out 1: high from the cycle after start acceptance until the end of the DONE cycle.
- `done` out 1: one-cycle pulse when placement is complete.
- `wr_en` out 1: one-cycle write strobe to the mine memory.
- `wr_x`, `wr_y` out 4 each: cell being written; valid only while `wr_en` is high.
- `placed` out 8: mines placed so far; holds its value after done until the next start.

## Operation
- `board_cols`, `board_rows`, `mine_count`, `safe_x` and `safe_y` are latched on start acceptance. Later input changes have no effect until the next start.
- Target = min(`mine_count`, cols*rows − excluded), floored at 0.
  - excluded = 9 with `SAFE_ZONE_EN`, otherwise 1.
  - Compute in 9-bit signed arithmetic.
- FSM states and transitions:
  - IDLE: on start go to CLEAR.
  - CLEAR: zero the 256-bit occupancy map and `placed` in one cycle. If target = 0 go to DONE, else go to GATHER.
  - GATHER: shift in 8 sampled bits, MSB first. The first 4 bits are x, the last 4 are y.
  - CHECK: reject if x ≥ cols, y ≥ rows, the map bit is already set, or the cell is protected. On reject go to GATHER; on accept go to PLACE.
  - PLACE: set the map bit, assert `wr_en` with `wr_x`/`wr_y`, increment `placed`. If `placed`+1 = target go to DONE, else go to GATHER.
  - DONE: assert `done` for one cycle, then go to IDLE.
- Sampling: a mod-`BIT_DIV` divider runs only in GATHER and restarts at 0 on entry. A bit is taken when the divider is 0.
- Accepted coordinates are always unique, in range and outside the protected set.
- Clamping of the target guarantees termination.

## Timing
- Reset values: all outputs 0, FSM in IDLE, occupancy map cleared, divider cleared.
- `start` sampled high at edge 0 → `busy` is high from after edge 0, with the FSM in CLEAR.
- Each attempt takes 8·`BIT_DIV` GATHER cycles plus 1 CHECK cycle.
- An accepted attempt adds 1 PLACE cycle, in which `wr_en` is high.
- `done` is high in the cycle after the final PLACE; `busy` drops after that cycle.
- Target = 0: CLEAR, then DONE. `done` is high in the second cycle after acceptance, with no writes.
- `start` while `busy` is ignored. No restart and no latch update occur.
- `start` in the same cycle as `done` is ignored; the FSM returns to IDLE first.
- `rst` mid-operation: immediate return to reset values. No further writes occur, and no `done` is produced.
- `wr_en` is never high in two consecutive cycles.

## Configuration
- `MINE_PLACER_SAFE_ZONE_EN`:
  - Defined: the protected set is the 3×3 neighbourhood of (`safe_x`, `safe_y`), clipped to the board, and excluded = 9 for clamping. The excluded count stays 9 even at edges, so placement is conservative.
  - Undefined: only the single cell (`safe_x`, `safe_y`) is protected, and excluded = 1.

## Test plan
- 8×8 board, `mine_count`=10, safe (3,3), `BIT_DIV`=1 → exactly 10 `wr_en` pulses, all coordinates unique and <8, none at (3,3). With the macro, none at (2..4, 2..4). `placed`=10 and a single `done`.
- 5×5 board, `mine_count`=20, safe (0,0), with the macro → target 16. Exactly 16 writes, all x,y <5, none in {0,1}×{0,1}, and `done`.
- `mine_count`=0 on 16×16 → no `wr_en`, and `done` high exactly 2 cycles after start acceptance.
- `start` pulsed again 5 cycles into a 16×16, 40-mine run with changed `mine_count`=3 → ignored, and exactly 40 writes.
- `rst` asserted after the 4th write of a 10-mine run → all outputs 0 immediately. A subsequent start with 2 mines yields exactly 2 writes, and `placed`=2.
- `BIT_DIV`=4, 4×4 board, 1 mine → the first CHECK occurs no earlier than 33 cycles after CLEAR, and `wr_en` comes after at least one full GATHER.
